// File: rtl/regfile_sb.sv
// regfile_sb - parametrised register file with per-register scoreboard.
//
// Two asynchronous read ports with optional same-cycle bypass of write data,
// two write ports (pipeline writeback and accelerator result return) and a
// busy bit per register. The decode stage uses the busy bits to stall on
// registers that still have an outstanding writer.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rs1_addr/rs2_addr        read addresses
//   rs1_data/rs2_data        read data (combinational)
//   rs1_busy/rs2_busy        scoreboard bit of each read address (combinational)
//   reg_write/rd_addr/wb_data       writeback port (wins on address clash)
//   acc_write/acc_addr/acc_data     accelerator port
//   issue_valid/issue_addr   marks issue_addr busy at the next edge
//   acc_conflict             registered; 1 for one cycle after an accelerator
//                            write was dropped in favour of writeback
module regfile_sb #(
    parameter int WIDTH   = 19,
    parameter int DEPTH   = 8,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             reg_write,
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             acc_write,
    input  logic [AW-1:0]    acc_addr,
    input  logic [WIDTH-1:0] acc_data,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_addr,
    output logic             acc_conflict
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;

    logic wb_en;
    logic acc_req;
    logic acc_en;
    logic iss_en;
    logic conflict_p0;

    // Address 0 is filtered out up front when hardwired, so it can never be
    // written, marked busy or raise a conflict.
    function automatic logic is_r0(input logic [AW-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    always_comb begin
        wb_en       = reg_write && !is_r0(rd_addr);
        acc_req     = acc_write && !is_r0(acc_addr);
        conflict_p0 = wb_en && acc_req && (rd_addr == acc_addr);
        acc_en      = acc_req && !conflict_p0;
        iss_en      = issue_valid && !is_r0(issue_addr);
    end

    // Read path: stored value, overridden by accelerator then writeback data
    // (later assignment wins, giving writeback the highest priority).
    always_comb begin
        rs1_data = mem[rs1_addr];
        if (BYPASS != 0 && acc_en && acc_addr == rs1_addr) rs1_data = acc_data;
        if (BYPASS != 0 && wb_en && rd_addr == rs1_addr)   rs1_data = wb_data;
        if (is_r0(rs1_addr))                               rs1_data = '0;
    end

    always_comb begin
        rs2_data = mem[rs2_addr];
        if (BYPASS != 0 && acc_en && acc_addr == rs2_addr) rs2_data = acc_data;
        if (BYPASS != 0 && wb_en && rd_addr == rs2_addr)   rs2_data = wb_data;
        if (is_r0(rs2_addr))                               rs2_data = '0;
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];

    // Stage p0 -> stored state (registers, busy bits, conflict flag)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy         <= '0;
            acc_conflict <= 1'b0;
        end else begin
            if (wb_en)  mem[rd_addr]  <= wb_data;
            if (acc_en) mem[acc_addr] <= acc_data;
            for (int i = 0; i < DEPTH; i++) begin
                if (iss_en && issue_addr == AW'(i))
                    busy[i] <= 1'b1;
                else if ((wb_en && rd_addr == AW'(i)) || (acc_en && acc_addr == AW'(i)))
                    busy[i] <= 1'b0;
            end
            acc_conflict <= conflict_p0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rs1_addr, rs2_addr;
    logic [18:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic        reg_write;
    logic [2:0]  rd_addr;
    logic [18:0] wb_data;
    logic        acc_write;
    logic [2:0]  acc_addr;
    logic [18:0] acc_data;
    logic        issue_valid;
    logic [2:0]  issue_addr;
    logic        acc_conflict;

    int total = 0;
    int bad   = 0;

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .reg_write(reg_write), .rd_addr(rd_addr), .wb_data(wb_data),
        .acc_write(acc_write), .acc_addr(acc_addr), .acc_data(acc_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .acc_conflict(acc_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [18:0] act, input logic [18:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %05h want %05h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; reg_write = 1'b0; acc_write = 1'b0; issue_valid = 1'b0;
        rd_addr = '0; acc_addr = '0; issue_addr = '0;
        wb_data = '0; acc_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic        rw;
        logic [2:0]  rd;
        logic [18:0] wd;
        logic        aw;
        logic [2:0]  aa;
        logic [18:0] ad;
        logic        iv;
        logic [2:0]  ia;
        logic [2:0]  a1;
        logic [2:0]  a2;
        logic [18:0] e1;
        logic [18:0] e2;
        logic        eb1;
        logic        eb2;
        logic        ec;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rw, input logic [2:0] rd, input logic [18:0] wd,
                       input logic aw, input logic [2:0] aa, input logic [18:0] ad,
                       input logic iv, input logic [2:0] ia,
                       input logic [2:0] a1, input logic [2:0] a2,
                       input logic [18:0] e1, input logic [18:0] e2,
                       input logic eb1, input logic eb2, input logic ec);
        vec_t v;
        v.rw = rw; v.rd = rd; v.wd = wd; v.aw = aw; v.aa = aa; v.ad = ad;
        v.iv = iv; v.ia = ia; v.a1 = a1; v.a2 = a2;
        v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2; v.ec = ec;
        vecs.push_back(v);
    endtask

    // ---------------- reference model ----------------
    logic [18:0] m_reg [8];
    logic        m_busy [8];
    logic        m_conf;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_reg[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_conf = 1'b0;
    endtask

    function automatic logic [18:0] model_read(input logic [2:0] a);
        if (a == 3'd0) return '0;
        if (reg_write && rd_addr == a) return wb_data;
        if (acc_write && acc_addr == a) return acc_data;
        return m_reg[a];
    endfunction

    // Applies the current inputs as one clock edge.
    task automatic model_edge();
        logic clash;
        if (rst) begin
            model_reset();
            return;
        end
        clash = reg_write && acc_write && rd_addr == acc_addr && rd_addr != 3'd0;
        if (acc_write && acc_addr != 3'd0 && !clash) begin
            m_reg[acc_addr] = acc_data;
            m_busy[acc_addr] = 1'b0;
        end
        if (reg_write && rd_addr != 3'd0) begin
            m_reg[rd_addr] = wb_data;
            m_busy[rd_addr] = 1'b0;
        end
        if (issue_valid && issue_addr != 3'd0) m_busy[issue_addr] = 1'b1;
        m_conf = clash;
    endtask

    initial begin
        idle();
        rs1_addr = '0; rs2_addr = '0;

        // Reset then readback sweep
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rs1_addr = 3'(a);
            rs2_addr = 3'(7 - a);
            #1;
            chk ("reset_rs1_data", rs1_data, 19'h0);
            chk ("reset_rs2_data", rs2_data, 19'h0);
            chkb("reset_rs1_busy", rs1_busy, 1'b0);
            chkb("reset_rs2_busy", rs2_busy, 1'b0);
        end
        chkb("reset_conflict", acc_conflict, 1'b0);

        // Vector table, applied from the reset state; outputs checked before the edge.
        //   rw    rd     wd           aw    aa     ad           iv    ia     a1     a2     e1           e2           eb1   eb2   ec
        add(1'b1, 3'd1, 19'd123,     1'b0, 3'd0, 19'h0,       1'b0, 3'd0, 3'd1, 3'd1, 19'd123,     19'd123,     1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 19'h0,       1'b0, 3'd0, 19'h0,       1'b0, 3'd0, 3'd1, 3'd0, 19'd123,     19'h0,       1'b0, 1'b0, 1'b0);
        add(1'b1, 3'd3, 19'h00AAA,   1'b1, 3'd3, 19'h7FFFF,   1'b0, 3'd0, 3'd3, 3'd2, 19'h00AAA,   19'h0,       1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 19'h0,       1'b0, 3'd0, 19'h0,       1'b0, 3'd0, 3'd3, 3'd3, 19'h00AAA,   19'h00AAA,   1'b0, 1'b0, 1'b1);
        add(1'b1, 3'd3, 19'h00AAA,   1'b1, 3'd5, 19'h7FFFF,   1'b0, 3'd0, 3'd3, 3'd5, 19'h00AAA,   19'h7FFFF,   1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 19'h0,       1'b0, 3'd0, 19'h0,       1'b0, 3'd0, 3'd5, 3'd3, 19'h7FFFF,   19'h00AAA,   1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 19'h0,       1'b0, 3'd0, 19'h0,       1'b1, 3'd4, 3'd4, 3'd4, 19'h0,       19'h0,       1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 19'h0,       1'b1, 3'd4, 19'h12345,   1'b0, 3'd0, 3'd1, 3'd4, 19'd123,     19'h12345,   1'b0, 1'b1, 1'b0);
        add(1'b0, 3'd0, 19'h0,       1'b0, 3'd0, 19'h0,       1'b0, 3'd0, 3'd4, 3'd4, 19'h12345,   19'h12345,   1'b0, 1'b0, 1'b0);
        add(1'b1, 3'd4, 19'h00321,   1'b0, 3'd0, 19'h0,       1'b1, 3'd4, 3'd4, 3'd4, 19'h00321,   19'h00321,   1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 19'h0,       1'b0, 3'd0, 19'h0,       1'b0, 3'd0, 3'd4, 3'd4, 19'h00321,   19'h00321,   1'b1, 1'b1, 1'b0);
        add(1'b1, 3'd0, 19'h7FFFF,   1'b0, 3'd0, 19'h0,       1'b1, 3'd0, 3'd0, 3'd0, 19'h0,       19'h0,       1'b0, 1'b0, 1'b0);
        add(1'b0, 3'd0, 19'h0,       1'b0, 3'd0, 19'h0,       1'b0, 3'd0, 3'd0, 3'd4, 19'h0,       19'h00321,   1'b0, 1'b1, 1'b0);

        foreach (vecs[i]) begin
            reg_write = vecs[i].rw; rd_addr = vecs[i].rd; wb_data = vecs[i].wd;
            acc_write = vecs[i].aw; acc_addr = vecs[i].aa; acc_data = vecs[i].ad;
            issue_valid = vecs[i].iv; issue_addr = vecs[i].ia;
            rs1_addr = vecs[i].a1; rs2_addr = vecs[i].a2;
            #2;
            chk ($sformatf("vec%0d_rs1_data", i), rs1_data, vecs[i].e1);
            chk ($sformatf("vec%0d_rs2_data", i), rs2_data, vecs[i].e2);
            chkb($sformatf("vec%0d_rs1_busy", i), rs1_busy, vecs[i].eb1);
            chkb($sformatf("vec%0d_rs2_busy", i), rs2_busy, vecs[i].eb2);
            chkb($sformatf("vec%0d_conflict", i), acc_conflict, vecs[i].ec);
            tick();
        end
        idle();

        // Reset mid-operation: r2 = 0x55, busy(6) = 1, then rst with a write to r2.
        reg_write = 1'b1; rd_addr = 3'd2; wb_data = 19'h00055;
        issue_valid = 1'b1; issue_addr = 3'd6;
        tick();
        idle();
        rs1_addr = 3'd2; rs2_addr = 3'd6;
        #1;
        chk ("midrst_pre_r2", rs1_data, 19'h00055);
        chkb("midrst_pre_busy6", rs2_busy, 1'b1);
        rst = 1'b1; reg_write = 1'b1; rd_addr = 3'd2; wb_data = 19'h00777;
        acc_write = 1'b1; acc_addr = 3'd2; acc_data = 19'h00001;
        tick();
        idle();
        #1;
        chk ("midrst_r2", rs1_data, 19'h0);
        chkb("midrst_busy6", rs2_busy, 1'b0);
        chkb("midrst_conflict", acc_conflict, 1'b0);

        // Randomized run against the reference model.
        rst = 1'b1;
        tick();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(63) == 0);
            reg_write   = 1'($urandom_range(1));
            acc_write   = 1'($urandom_range(1));
            issue_valid = 1'($urandom_range(1));
            rd_addr     = 3'($urandom_range(7));
            acc_addr    = 3'($urandom_range(7));
            issue_addr  = 3'($urandom_range(7));
            rs1_addr    = 3'($urandom_range(7));
            rs2_addr    = 3'($urandom_range(7));
            wb_data     = 19'($urandom);
            acc_data    = 19'($urandom);
            #2;
            if (!rst) begin
                chk ("rand_rs1_data", rs1_data, model_read(rs1_addr));
                chk ("rand_rs2_data", rs2_data, model_read(rs2_addr));
                chkb("rand_rs1_busy", rs1_busy, m_busy[rs1_addr]);
                chkb("rand_rs2_busy", rs2_busy, m_busy[rs2_addr]);
                chkb("rand_conflict", acc_conflict, m_conf);
            end
            tick();
            model_edge();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's 8x19 register file.
- Two asynchronous read ports with optional same-cycle write-to-read bypass.
- Two write ports: pipeline writeback, plus FFT/crypto accelerator result return.
- Per-register scoreboard (busy) bits let the decode stage stall on registers with an outstanding writer. Sits between decode/issue and writeback in the pipelined SoC.

Parameters:
- WIDTH, 19, data width of each register.
- DEPTH, 8, number of registers; must be a power of two, at least 2.
- AW, $clog2(DEPTH), register address width (derived, not overridden).
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = read ports return stored value only.
- ZERO_R0, 1, 1 = register 0 is hardwired to zero and is never busy.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- rs1_addr  in  AW  read port 1 address
- rs2_addr  in  AW  read port 2 address
- rs1_data  out  WIDTH  read port 1 data (combinational)
- rs2_data  out  WIDTH  read port 2 data (combinational)
- rs1_busy  out  1  scoreboard bit of rs1_addr (combinational)
- rs2_busy  out  1  scoreboard bit of rs2_addr (combinational)
- reg_write  in  1  writeback port write enable
- rd_addr  in  AW  writeback port address
- wb_data  in  WIDTH  writeback port data
- acc_write  in  1  accelerator port write enable
- acc_addr  in  AW  accelerator port address
- acc_data  in  WIDTH  accelerator port data
- issue_valid  in  1  an instruction with destination issue_addr was issued this cycle
- issue_addr  in  AW  destination register to mark busy
- acc_conflict  out  1  registered; pulses 1 cycle after an accelerator write is dropped

Behaviour:
- Reset (rst=1 at clk edge):
  - All registers are set to 0.
  - All busy bits are cleared.
  - acc_conflict is set to 0.
  - rst overrides every write and issue in the same cycle.
  - After reset, rs*_data = 0 and rs*_busy = 0 for every address.
- Write, port priority:
  - Writeback port wins.
  - If reg_write and acc_write are both high and rd_addr == acc_addr, only wb_data is stored, and acc_conflict = 1 on the next cycle (0 otherwise).
  - Different addresses: both writes commit in the same edge.
- Write latency: data is stored at the rising edge where the enable is high. A plain read sees it from the next cycle.
- Bypass (BYPASS=1):
  - If a read address equals an active write address this cycle, the read returns the write data.
  - Priority: wb_data first, then acc_data, then the stored value.
  - This is combinational in the same cycle.
- BYPASS=0: reads return the stored value only.
- Scoreboard:
  - A busy bit is set at the edge where issue_valid is high for that address.
  - It is cleared at the edge where either write port writes that address, without a simultaneous set.
  - If a set and a clear hit the same address in the same cycle, the set wins (new writer outstanding) and the data write still commits.
  - Writing a non-busy register is legal and leaves busy = 0.
  - A dropped accelerator write clears nothing; the winning writeback write clears the bit.
  - rs*_busy reflects the stored bit and is not bypassed.
- ZERO_R0=1:
  - Writes to address 0 are ignored, with no conflict flag.
  - Issues to address 0 are ignored.
  - Reads of address 0 return 0 and busy 0, including under bypass.
- No internal FSM beyond the busy and conflict state. There is no back-pressure: all inputs are accepted every cycle.

Test Plan:
- Reset then readback:
  - Stimulus: assert rst for 2 cycles, then sweep rs1_addr and rs2_addr over 0..7.
  - Required: every rs*_data = 0, every rs*_busy = 0, acc_conflict = 0.
- Basic write/read:
  - Stimulus: reg_write=1, rd_addr=1, wb_data=123 for one cycle, then rs1_addr=1.
  - Required: rs1_data = 123 from the next cycle onward. With BYPASS=1 and rs1_addr=1 during the write cycle, rs1_data = 123 in the same cycle.
- Dual-write conflict:
  - Stimulus: reg_write=1, rd_addr=3, wb_data=0x00AAA together with acc_write=1, acc_addr=3, acc_data=0x7FFFF.
  - Required: r3 = 0x00AAA; acc_conflict = 1 for exactly one cycle; a same-cycle bypass read of address 3 returns 0x00AAA.
  - Stimulus: repeat with acc_addr=5.
  - Required: r3 = 0x00AAA, r5 = 0x7FFFF, acc_conflict = 0.
- Scoreboard:
  - Stimulus: issue_valid=1, issue_addr=4.
  - Required: rs2_busy = 1 for rs2_addr=4 next cycle.
  - Stimulus: acc_write to address 4 with data 0x12345.
  - Required: busy = 0 next cycle, rs2_data = 0x12345.
  - Stimulus: issue_valid to address 4 and reg_write to address 4 in the same cycle.
  - Required: busy stays 1 and the data updates.
- Zero register:
  - Stimulus: reg_write to address 0 with 0x7FFFF and issue_valid to address 0.
  - Required: reads of address 0 return 0 and busy 0 in both the same and the next cycle.
- Reset mid-operation:
  - Stimulus: with r2 = 0x00055 and busy(6) = 1, assert rst in the same cycle as reg_write to address 2 with 0x00777.
  - Required: next cycle r2 = 0, busy(6) = 0, acc_conflict = 0.
